uart_apb_sequencer: RTL and testbench

APB master that owns the APB port of the UART core and is its only bus master. It arbitrates three internal requesters onto that port:
- a configuration engine that programs the two baud-divisor registers;
- a 4-deep TX byte FIFO that feeds the transmit-data register, gated by TXRDY;
- an RX drain that reads the receive-data register when RXRDY is high.

It sits between the system-side byte streams and the UART core, and removes all APB sequencing from the rest of the design.

---
 rtl/uart_apb_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_uart_apb_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_sequencer.sv
// APB master for the UART core: arbitrates divisor config,
// a TX byte FIFO and an RX drain onto one APB port.
module uart_apb_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  ADDR_DIVLO = 2'b00,
  parameter logic [1:0]  ADDR_DIVHI = 2'b01,
  parameter logic [1:0]  ADDR_TXD   = 2'b10,
  parameter logic [1:0]  ADDR_RXD   = 2'b11
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        CFG_START,
  input  logic [15:0] CFG_DIV,
  output logic        CFG_BUSY,
  output logic        CFG_DONE,
  input  logic        TX_VALID,
  input  logic [7:0]  TX_DATA,
  output logic        TX_READY,
  output logic        RX_VALID,
  output logic [7:0]  RX_DATA,
  output logic        M_PSEL,
  output logic        M_PENABLE,
  output logic        M_PWRITE,
  output logic [1:0]  M_PADDR,
  output logic [7:0]  M_PWDATA,
  input  logic [7:0]  M_PRDATA,
  input  logic        M_PREADY,
  input  logic        TXRDY,
  input  logic        RXRDY
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS
  } state_t;

  typedef enum logic [1:0] {
    SRC_LO, SRC_HI, SRC_RX, SRC_TX
  } src_t;

  state_t state, state_n;
  src_t   src, src_n;

  logic [15:0] div_q;
  logic        lo_pend, hi_pend, done_pre;
  logic        rx_armed, tx_armed;
  logic        rxrdy_q, txrdy_q;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, count, count_n;
  logic        empty, push, pop, xfer_done;
  logic        cfg_go, rx_go, tx_go;

  logic        wr_n;
  logic [1:0]  addr_n;
  logic [7:0]  wdata_n;

  assign count     = wptr - rptr;
  assign empty     = (count == '0);
  assign push      = TX_VALID & TX_READY;
  assign xfer_done = (state == ACCESS) & M_PREADY;
  assign pop       = xfer_done & (src == SRC_TX);
  assign count_n   = count + (AW+1)'(push)
                   - (AW+1)'(pop);

  assign cfg_go = lo_pend | hi_pend;
  assign rx_go  = rxrdy_q & rx_armed;
  assign tx_go  = ~empty & txrdy_q & tx_armed;

  always_comb begin
    state_n = state;
    src_n   = src;
    wr_n    = M_PWRITE;
    addr_n  = M_PADDR;
    wdata_n = M_PWDATA;
    unique case (state)
      IDLE: begin
        if (cfg_go | rx_go | tx_go) begin
          state_n = SETUP;
          if (hi_pend)      src_n = SRC_HI;
          else if (lo_pend) src_n = SRC_LO;
          else if (rx_go)   src_n = SRC_RX;
          else              src_n = SRC_TX;
        end
      end
      SETUP:   state_n = ACCESS;
      ACCESS:  if (M_PREADY) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // bus fields load once at SETUP and hold through ACCESS
    if (state == IDLE && state_n == SETUP) begin
      unique case (src_n)
        SRC_LO: begin
          wr_n    = 1'b1;
          addr_n  = ADDR_DIVLO;
          wdata_n = div_q[7:0];
        end
        SRC_HI: begin
          wr_n    = 1'b1;
          addr_n  = ADDR_DIVHI;
          wdata_n = div_q[15:8];
        end
        SRC_RX: begin
          wr_n    = 1'b0;
          addr_n  = ADDR_RXD;
          wdata_n = 8'h00;
        end
        default: begin
          wr_n    = 1'b1;
          addr_n  = ADDR_TXD;
          wdata_n = mem[rptr[AW-1:0]];
        end
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) mem[wptr[AW-1:0]] <= TX_DATA;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      src       <= SRC_LO;
      M_PSEL    <= 1'b0;
      M_PENABLE <= 1'b0;
      M_PWRITE  <= 1'b0;
      M_PADDR   <= 2'b00;
      M_PWDATA  <= 8'h00;
      div_q     <= 16'h0000;
      lo_pend   <= 1'b0;
      hi_pend   <= 1'b0;
      done_pre  <= 1'b0;
      CFG_BUSY  <= 1'b0;
      CFG_DONE  <= 1'b0;
      rx_armed  <= 1'b1;
      tx_armed  <= 1'b1;
      rxrdy_q   <= 1'b0;
      txrdy_q   <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      TX_READY  <= 1'b1;
      RX_VALID  <= 1'b0;
      RX_DATA   <= 8'h00;
    end else begin
      state     <= state_n;
      src       <= src_n;
      M_PSEL    <= (state_n != IDLE);
      M_PENABLE <= (state_n == ACCESS);
      M_PWRITE  <= wr_n;
      M_PADDR   <= addr_n;
      M_PWDATA  <= wdata_n;
      rxrdy_q   <= RXRDY;
      txrdy_q   <= TXRDY;
      done_pre  <= 1'b0;
      CFG_DONE  <= done_pre;
      RX_VALID  <= 1'b0;
      if (CFG_START && !CFG_BUSY) begin
        div_q    <= CFG_DIV;
        lo_pend  <= 1'b1;
        CFG_BUSY <= 1'b1;
      end
      if (done_pre) CFG_BUSY <= 1'b0;
      if (xfer_done) begin
        unique case (src)
          SRC_LO: begin
            lo_pend <= 1'b0;
            hi_pend <= 1'b1;
          end
          SRC_HI: begin
            hi_pend  <= 1'b0;
            done_pre <= 1'b1;
          end
          SRC_RX: begin
            RX_DATA  <= M_PRDATA;
            RX_VALID <= 1'b1;
          end
          default: ;
        endcase
      end
      // one access per ready level; re-arm on a low sample
      if (xfer_done && src == SRC_RX) rx_armed <= 1'b0;
      else if (!RXRDY)                rx_armed <= 1'b1;
      if (pop)         tx_armed <= 1'b0;
      else if (!TXRDY) tx_armed <= 1'b1;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      TX_READY <= (count_n != FULL);
    end
  end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed bench for uart_apb_sequencer: cycle table for
// config/RX, plus TX stream, collision, wait and reset runs.
module tb_uart_apb_sequencer;

  logic        PCLK, PRESET;
  logic        CFG_START;
  logic [15:0] CFG_DIV;
  logic        CFG_BUSY, CFG_DONE;
  logic        TX_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_READY, RX_VALID;
  logic [7:0]  RX_DATA;
  logic        M_PSEL, M_PENABLE, M_PWRITE;
  logic [1:0]  M_PADDR;
  logic [7:0]  M_PWDATA, M_PRDATA;
  logic        M_PREADY, TXRDY, RXRDY;

  uart_apb_sequencer dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .CFG_START(CFG_START), .CFG_DIV(CFG_DIV),
    .CFG_BUSY(CFG_BUSY), .CFG_DONE(CFG_DONE),
    .TX_VALID(TX_VALID), .TX_DATA(TX_DATA),
    .TX_READY(TX_READY),
    .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE),
    .M_PWRITE(M_PWRITE), .M_PADDR(M_PADDR),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA),
    .M_PREADY(M_PREADY),
    .TXRDY(TXRDY), .RXRDY(RXRDY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  // core model: TXRDY drops for 224 cycles after each TXD write
  logic tx_en;
  int   txlow;
  assign TXRDY = tx_en && (txlow == 0);

  always @(posedge PCLK) begin
    if (PRESET) txlow <= 0;
    else if (M_PSEL && M_PENABLE && M_PREADY &&
             M_PWRITE && M_PADDR == 2'b10)
      txlow <= 224;
    else if (txlow != 0) txlow <= txlow - 1;
  end

  typedef struct packed {
    logic [1:0] a;
    logic       w;
    logic [7:0] d;
  } xfer_t;

  xfer_t log_q[$];
  int    bad_tx = 0;

  always @(negedge PCLK) begin
    if (M_PSEL && M_PENABLE && M_PREADY) begin
      log_q.push_back({M_PADDR, M_PWRITE,
                       M_PWRITE ? M_PWDATA : 8'h00});
      if (M_PWRITE && M_PADDR == 2'b10 && !TXRDY)
        bad_tx++;
    end
  end

  typedef struct {
    logic        start;
    logic [15:0] div;
    logic        rxrdy;
    logic [7:0]  prdata;
    logic        psel, pen, pwr;
    logic [1:0]  addr;
    logic [7:0]  wd;
    logic        busy, done, rxv;
    logic [7:0]  rxd;
  } vec_t;

  function automatic vec_t mk(
    logic st, logic [15:0] dv, logic rr, logic [7:0] pr,
    logic ps, logic pe, logic pw, logic [1:0] ad,
    logic [7:0] wd, logic bz, logic dn, logic rv,
    logic [7:0] rd);
    vec_t v;
    v.start = st; v.div = dv; v.rxrdy = rr; v.prdata = pr;
    v.psel = ps; v.pen = pe; v.pwr = pw; v.addr = ad;
    v.wd = wd; v.busy = bz; v.done = dn; v.rxv = rv;
    v.rxd = rd;
    return v;
  endfunction

  task automatic sync();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    sync();
    PRESET = 1'b1;
    CFG_START = 1'b0; CFG_DIV = 16'h0;
    TX_VALID = 1'b0; TX_DATA = 8'h0;
    M_PRDATA = 8'h0; M_PREADY = 1'b1;
    RXRDY = 1'b0; tx_en = 1'b0;
    sync();
    PRESET = 1'b0;
    log_q.delete();
    bad_tx = 0;
  endtask

  // call at posedge+1; returns at posedge+1 after acceptance
  task automatic push(input logic [7:0] b);
    bit ok;
    ok = 0;
    TX_VALID = 1'b1;
    TX_DATA  = b;
    for (int n = 0; n < 100; n++) begin
      @(negedge PCLK);
      if (TX_READY) begin
        ok = 1;
        break;
      end
    end
    sync();
    TX_VALID = 1'b0;
    chk("push_accept", 32'(ok), 1);
  endtask

  vec_t vt[20];
  logic [7:0] txb[5];
  xfer_t exp_c[4];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int n, idle;
    logic [1:0] a0;
    logic [7:0] d0;

    // cycle 0: CFG_START; cycle 4: ignored restart
    vt[0]  = mk(1,16'h00E0,0,8'h00, 0,0,0,0,8'h00, 0,0,0,8'h00);
    vt[1]  = mk(0,16'h0000,0,8'h00, 0,0,0,0,8'h00, 1,0,0,8'h00);
    vt[2]  = mk(0,16'h0000,0,8'h00, 1,0,1,0,8'hE0, 1,0,0,8'h00);
    vt[3]  = mk(0,16'h0000,0,8'h00, 1,1,1,0,8'hE0, 1,0,0,8'h00);
    vt[4]  = mk(1,16'h1234,0,8'h00, 0,0,0,0,8'h00, 1,0,0,8'h00);
    vt[5]  = mk(0,16'h0000,0,8'h00, 1,0,1,1,8'h00, 1,0,0,8'h00);
    vt[6]  = mk(0,16'h0000,0,8'h00, 1,1,1,1,8'h00, 1,0,0,8'h00);
    vt[7]  = mk(0,16'h0000,0,8'h00, 0,0,0,0,8'h00, 1,0,0,8'h00);
    vt[8]  = mk(0,16'h0000,0,8'h00, 0,0,0,0,8'h00, 0,1,0,8'h00);
    vt[9]  = mk(0,16'h0000,0,8'h00, 0,0,0,0,8'h00, 0,0,0,8'h00);
    // cycle 10: RXRDY rises, RX_VALID expected at cycle 14
    vt[10] = mk(0,16'h0000,1,8'h55, 0,0,0,0,8'h00, 0,0,0,8'h00);
    vt[11] = mk(0,16'h0000,1,8'h55, 0,0,0,0,8'h00, 0,0,0,8'h00);
    vt[12] = mk(0,16'h0000,1,8'h55, 1,0,0,3,8'h00, 0,0,0,8'h00);
    vt[13] = mk(0,16'h0000,1,8'h55, 1,1,0,3,8'h00, 0,0,0,8'h00);
    vt[14] = mk(0,16'h0000,1,8'h55, 0,0,0,0,8'h00, 0,0,1,8'h55);
    vt[15] = mk(0,16'h0000,1,8'h55, 0,0,0,0,8'h00, 0,0,0,8'h55);
    vt[16] = mk(0,16'h0000,1,8'h55, 0,0,0,0,8'h00, 0,0,0,8'h55);
    vt[17] = mk(0,16'h0000,1,8'h55, 0,0,0,0,8'h00, 0,0,0,8'h55);
    vt[18] = mk(0,16'h0000,1,8'h55, 0,0,0,0,8'h00, 0,0,0,8'h55);
    vt[19] = mk(0,16'h0000,0,8'h00, 0,0,0,0,8'h00, 0,0,0,8'h55);

    txb = '{8'h9A, 8'h0D, 8'h55, 8'hAA, 8'h3C};

    PRESET = 1'b1;
    CFG_START = 1'b0; CFG_DIV = 16'h0;
    TX_VALID = 1'b0; TX_DATA = 8'h0;
    M_PRDATA = 8'h0; M_PREADY = 1'b1;
    RXRDY = 1'b0; tx_en = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;

    @(negedge PCLK);
    chk("rst_psel",   32'(M_PSEL), 0);
    chk("rst_pen",    32'(M_PENABLE), 0);
    chk("rst_pwrite", 32'(M_PWRITE), 0);
    chk("rst_paddr",  32'(M_PADDR), 0);
    chk("rst_pwdata", 32'(M_PWDATA), 0);
    chk("rst_busy",   32'(CFG_BUSY), 0);
    chk("rst_done",   32'(CFG_DONE), 0);
    chk("rst_txrdy",  32'(TX_READY), 1);
    chk("rst_rxv",    32'(RX_VALID), 0);
    chk("rst_rxd",    32'(RX_DATA), 0);

    for (int i = 0; i < 20; i++) begin
      sync();
      CFG_START = vt[i].start;
      CFG_DIV   = vt[i].div;
      RXRDY     = vt[i].rxrdy;
      M_PRDATA  = vt[i].prdata;
      @(negedge PCLK);
      ok = (M_PSEL == vt[i].psel) &&
           (M_PENABLE == vt[i].pen) &&
           (CFG_BUSY == vt[i].busy) &&
           (CFG_DONE == vt[i].done) &&
           (RX_VALID == vt[i].rxv) &&
           (RX_DATA == vt[i].rxd) &&
           (!vt[i].psel ||
            (M_PWRITE == vt[i].pwr &&
             M_PADDR == vt[i].addr &&
             (!vt[i].pwr || M_PWDATA == vt[i].wd)));
      nchk++;
      if (!ok) begin
        nerr++;
        $display({"FAIL vec[%0d]: got sel/en/wr/a/d=%b%b%b/%0h/%h",
                  " busy/done/rxv/rxd=%b%b%b/%h expected",
                  " %b%b%b/%0h/%h %b%b%b/%h"},
                 i, M_PSEL, M_PENABLE, M_PWRITE, M_PADDR,
                 M_PWDATA, CFG_BUSY, CFG_DONE, RX_VALID,
                 RX_DATA, vt[i].psel, vt[i].pen, vt[i].pwr,
                 vt[i].addr, vt[i].wd, vt[i].busy,
                 vt[i].done, vt[i].rxv, vt[i].rxd);
      end
    end

    // TX stream: fill FIFO while the core is not ready
    do_reset();
    for (int i = 0; i < 4; i++) push(txb[i]);
    @(negedge PCLK);
    chk("tx_full_ready", 32'(TX_READY), 0);
    TX_VALID = 1'b1;
    TX_DATA  = txb[4];
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      if (TX_READY) ok = 0;
    end
    chk("tx_full_hold", 32'(ok), 1);
    chk("tx_no_write_early", log_q.size(), 0);
    tx_en = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (TX_READY) begin
        ok = 1;
        break;
      end
    end
    n = log_q.size();
    sync();
    TX_VALID = 1'b0;
    chk("tx_5th_accept", 32'(ok), 1);
    chk("tx_5th_after_pop", n, 1);
    for (int i = 0; i < 1500 && log_q.size() < 5; i++)
      @(negedge PCLK);
    chk("tx_write_count", log_q.size(), 5);
    for (int i = 0; i < 5 && i < log_q.size(); i++)
      chk($sformatf("tx_write[%0d]", i), 32'(log_q[i]),
          32'(xfer_t'({2'b10, 1'b1, txb[i]})));
    chk("tx_no_write_busy", bad_tx, 0);

    // collision: config, RX and TX all become eligible together
    do_reset();
    tx_en = 1'b1;
    TX_VALID = 1'b1; TX_DATA = 8'hC3;
    CFG_START = 1'b1; CFG_DIV = 16'hABCD;
    RXRDY = 1'b1; M_PRDATA = 8'h77;
    sync();
    TX_VALID = 1'b0;
    CFG_START = 1'b0;
    for (int i = 0; i < 60 && log_q.size() < 4; i++)
      @(negedge PCLK);
    exp_c = '{{2'b00, 1'b1, 8'hCD}, {2'b01, 1'b1, 8'hAB},
              {2'b11, 1'b0, 8'h00}, {2'b10, 1'b1, 8'hC3}};
    chk("col_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk($sformatf("col_order[%0d]", i),
          32'(log_q[i]), 32'(exp_c[i]));
    chk("col_rxdata", 32'(RX_DATA), 32'h77);
    RXRDY = 1'b0;

    // wait states on the DIVLO write
    do_reset();
    M_PREADY = 1'b0;
    CFG_START = 1'b1; CFG_DIV = 16'h5AA5;
    sync();
    CFG_START = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      if (M_PSEL) break;
    end
    a0 = M_PADDR;
    d0 = M_PWDATA;
    chk("ws_setup_addr", 32'(a0), 0);
    chk("ws_setup_data", 32'(d0), 32'hA5);
    ok = 1;
    n = 0;
    @(negedge PCLK);
    while (M_PENABLE && n < 10) begin
      n++;
      if (M_PADDR != a0 || M_PWDATA != d0 || !M_PSEL)
        ok = 0;
      if (n == 4) M_PREADY = 1'b1;
      @(negedge PCLK);
    end
    chk("ws_access_len", n, 4);
    chk("ws_stable", 32'(ok), 1);
    idle = 0;
    while (!M_PSEL && idle < 10) begin
      idle++;
      @(negedge PCLK);
    end
    chk("ws_idle_gap", idle, 1);
    chk("ws_next_setup",
        32'({M_PENABLE, M_PADDR, M_PWDATA}),
        32'({1'b0, 2'b01, 8'h5A}));

    // reset in the middle of a TXD access
    do_reset();
    tx_en = 1'b1;
    M_PREADY = 1'b0;
    push(8'hA1);
    push(8'hB2);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (M_PENABLE && M_PADDR == 2'b10) begin
        ok = 1;
        break;
      end
    end
    chk("rst_mid_reached", 32'(ok), 1);
    PRESET = 1'b1;
    sync();
    PRESET = 1'b0;
    M_PREADY = 1'b1;
    @(negedge PCLK);
    chk("rst_mid_psel", 32'(M_PSEL), 0);
    chk("rst_mid_pen",  32'(M_PENABLE), 0);
    chk("rst_mid_txrdy", 32'(TX_READY), 1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge PCLK);
      if (M_PSEL || CFG_DONE || RX_VALID) n++;
    end
    chk("rst_mid_quiet", n, 0);
    chk("rst_mid_nolog", log_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
